div_ctrl: RTL and testbench

Sequencing controller for the shared signed (div_gen_0) and unsigned (div_gen_1) divider IPs used by DIV/DIVU in the execute stage. It accepts one division request at a time and drives the IP's AXI-stream operand handshake without ever retracting tvalid. It captures the quotient and remainder and holds them until the pipeline consumes them. On a pipeline flush it drains the in-flight result so that a stale result is never delivered to a later instruction. Its done output is the execute stage's ready_go term for divide instructions.

---
 rtl/div_ctrl.sv | 132 +++++++++++++
 tb/tb_div_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
// Sequencing controller for the shared signed/unsigned divider IPs: one request
// at a time, non-retracting operand handshake, held result, flush-safe draining.
module div_ctrl #(
   parameter int DW = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            req_valid,
   input  logic            req_signed,
   input  logic [DW-1:0]   req_dividend,
   input  logic [DW-1:0]   req_divisor,
   output logic            req_ready,
   output logic            done,
   input  logic            res_ack,
   output logic [DW-1:0]   quotient,
   output logic [DW-1:0]   remainder,
   output logic            div_s_tvalid,
   output logic            div_u_tvalid,
   input  logic            divisor_tready,
   input  logic            dividend_tready,
   output logic [DW-1:0]   div_tdata_dividend,
   output logic [DW-1:0]   div_tdata_divisor,
   input  logic            dout_s_tvalid,
   input  logic [2*DW-1:0] dout_s_tdata,
   input  logic            dout_u_tvalid,
   input  logic [2*DW-1:0] dout_u_tdata
);

   typedef enum logic [2:0] {IDLE, SEND, WAIT, DONE, DRAIN} state_e;

   state_e          state_q, state_d;
   logic            sel_signed_q, sel_signed_d;
   logic            dvs_sent_q, dvs_sent_d;
   logic            dvd_sent_q, dvd_sent_d;
   logic            drain_q, drain_d;
   logic [DW-1:0]   dvd_q, dvd_d;
   logic [DW-1:0]   dvs_q, dvs_d;
   logic [DW-1:0]   quot_q, quot_d;
   logic [DW-1:0]   rem_q, rem_d;
   logic            dout_vld;
   logic [2*DW-1:0] dout_data;
   logic            send_vld;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         sel_signed_q <= 1'b0;
         dvs_sent_q   <= 1'b0;
         dvd_sent_q   <= 1'b0;
         drain_q      <= 1'b0;
         dvd_q        <= '0;
         dvs_q        <= '0;
         quot_q       <= '0;
         rem_q        <= '0;
      end else begin
         state_q      <= state_d;
         sel_signed_q <= sel_signed_d;
         dvs_sent_q   <= dvs_sent_d;
         dvd_sent_q   <= dvd_sent_d;
         drain_q      <= drain_d;
         dvd_q        <= dvd_d;
         dvs_q        <= dvs_d;
         quot_q       <= quot_d;
         rem_q        <= rem_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      sel_signed_d = sel_signed_q;
      dvs_sent_d   = dvs_sent_q;
      dvd_sent_d   = dvd_sent_q;
      drain_d      = drain_q;
      dvd_d        = dvd_q;
      dvs_d        = dvs_q;
      quot_d       = quot_q;
      rem_d        = rem_q;
      dout_vld     = sel_signed_q ? dout_s_tvalid : dout_u_tvalid;
      dout_data    = sel_signed_q ? dout_s_tdata  : dout_u_tdata;
      case (state_q)
         IDLE: begin
            if (req_valid && !flush) begin
               state_d      = SEND;
               sel_signed_d = req_signed;
               dvd_d        = req_dividend;
               dvs_d        = req_divisor;
               dvs_sent_d   = 1'b0;
               dvd_sent_d   = 1'b0;
               drain_d      = 1'b0;
            end
         end
         SEND: begin
            // tvalid stays up until each channel handshakes; a flush is only remembered
            if (divisor_tready)  dvs_sent_d = 1'b1;
            if (dividend_tready) dvd_sent_d = 1'b1;
            if (flush)           drain_d    = 1'b1;
            if (dvs_sent_d && dvd_sent_d) state_d = drain_d ? DRAIN : WAIT;
         end
         WAIT: begin
            if (flush) begin
               state_d = dout_vld ? IDLE : DRAIN;
            end else if (dout_vld) begin
               quot_d  = dout_data[2*DW-1:DW];
               rem_d   = dout_data[DW-1:0];
               state_d = DONE;
            end
         end
         DONE: begin
            if (flush || res_ack) state_d = IDLE;
         end
         DRAIN: begin
            if (dout_vld) begin
               drain_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign send_vld           = (state_q == SEND) && !(dvs_sent_q && dvd_sent_q);
   assign div_s_tvalid       = send_vld && sel_signed_q;
   assign div_u_tvalid       = send_vld && !sel_signed_q;
   assign req_ready          = (state_q == IDLE);
   assign done               = (state_q == DONE);
   assign quotient           = quot_q;
   assign remainder          = rem_q;
   assign div_tdata_dividend = dvd_q;
   assign div_tdata_divisor  = dvs_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: behavioural divider IP model with programmable latency,
// directed scenarios and randomized operations checked against plain arithmetic.
module tb_div_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_signed = 1'b0;
   logic [31:0] req_dividend = '0;
   logic [31:0] req_divisor = '0;
   logic        req_ready, done;
   logic        res_ack = 1'b0;
   logic [31:0] quotient, remainder;
   logic        div_s_tvalid, div_u_tvalid;
   logic        divisor_tready = 1'b1;
   logic        dividend_tready = 1'b1;
   logic [31:0] div_tdata_dividend, div_tdata_divisor;
   logic        dout_s_tvalid = 1'b0;
   logic [63:0] dout_s_tdata = '0;
   logic        dout_u_tvalid = 1'b0;
   logic [63:0] dout_u_tdata = '0;

   int checks = 0;
   int errors = 0;
   int ip_lat = 4;

   div_ctrl #(.DW(32)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .req_valid(req_valid), .req_signed(req_signed),
      .req_dividend(req_dividend), .req_divisor(req_divisor),
      .req_ready(req_ready), .done(done), .res_ack(res_ack),
      .quotient(quotient), .remainder(remainder),
      .div_s_tvalid(div_s_tvalid), .div_u_tvalid(div_u_tvalid),
      .divisor_tready(divisor_tready), .dividend_tready(dividend_tready),
      .div_tdata_dividend(div_tdata_dividend), .div_tdata_divisor(div_tdata_divisor),
      .dout_s_tvalid(dout_s_tvalid), .dout_s_tdata(dout_s_tdata),
      .dout_u_tvalid(dout_u_tvalid), .dout_u_tdata(dout_u_tdata)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] q, r;
      if (b == 0) return {32'hFFFF_FFFF, a};
      if (s) begin
         q = $unsigned($signed(a) / $signed(b));
         r = $unsigned($signed(a) % $signed(b));
      end else begin
         q = a / b;
         r = a % b;
      end
      return {q, r};
   endfunction

   // Divider IP model: collects both operand beats, answers ip_lat cycles later;
   // the idle IP emits random noise results that the controller must ignore.
   logic [63:0] pend_data[$];
   int          pend_cnt[$];
   bit          got_dvd = 0, got_dvs = 0, cap_s = 0;
   logic [31:0] cap_a, cap_b;

   always @(negedge clk) begin
      dout_s_tvalid = 1'b0;
      dout_u_tvalid = 1'b0;
      for (int i = 0; i < pend_cnt.size(); i++) pend_cnt[i]--;
      if (pend_cnt.size() > 0 && pend_cnt[0] <= 0) begin
         if (cap_s) begin dout_s_tvalid = 1'b1; dout_s_tdata = pend_data[0]; end
         else       begin dout_u_tvalid = 1'b1; dout_u_tdata = pend_data[0]; end
         void'(pend_cnt.pop_front());
         void'(pend_data.pop_front());
      end
      if ($urandom_range(3) == 0) begin
         if (cap_s) begin dout_u_tvalid = 1'b1; dout_u_tdata = {$urandom, $urandom}; end
         else       begin dout_s_tvalid = 1'b1; dout_s_tdata = {$urandom, $urandom}; end
      end
      if (div_s_tvalid || div_u_tvalid) begin
         cap_s = div_s_tvalid;
         if (dividend_tready && !got_dvd) begin got_dvd = 1; cap_a = div_tdata_dividend; end
         if (divisor_tready && !got_dvs)  begin got_dvs = 1; cap_b = div_tdata_divisor; end
         if (got_dvd && got_dvs) begin
            pend_data.push_back(ref_div(cap_s, cap_a, cap_b));
            pend_cnt.push_back(ip_lat);
            got_dvd = 0;
            got_dvs = 0;
         end
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic issue(input bit s, input logic [31:0] a, input logic [31:0] b);
      int n = 0;
      while (!req_ready && n < 100) begin step(); n++; end
      if (!req_ready) begin
         checks++; errors++;
         $display("FAIL issue_timeout req_ready=%0b required 1", req_ready);
      end
      req_valid = 1'b1; req_signed = s; req_dividend = a; req_divisor = b;
      step();
      req_valid = 1'b0;
   endtask

   // Called in the cycle after acceptance; lat is the cycle (1 = T+1) where done shows.
   task automatic wait_done(input bit s, input int stall, output int lat, output int tv_cyc,
                            output bit other_seen);
      lat = -1; tv_cyc = 0; other_seen = 0;
      for (int n = 1; n < 200; n++) begin
         divisor_tready = (n > stall);
         if (s ? div_s_tvalid : div_u_tvalid) tv_cyc++;
         if (s ? div_u_tvalid : div_s_tvalid) other_seen = 1;
         if (done) begin lat = n; break; end
         step();
      end
      divisor_tready = 1'b1;
   endtask

   task automatic ack_result();
      res_ack = 1'b1;
      checks++;
      if (req_ready !== 1'b0) begin
         errors++; $display("FAIL ack_spacing req_ready=%0b required 0", req_ready);
      end
      step();
      res_ack = 1'b0;
      checks++;
      if (done !== 1'b0 || req_ready !== 1'b1) begin
         errors++; $display("FAIL ack_release done=%0b req_ready=%0b required 0/1", done, req_ready);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; step(); step(); reset = 1'b0;
      checks++;
      if ({done, div_s_tvalid, div_u_tvalid, quotient, remainder, div_tdata_dividend,
           div_tdata_divisor} !== '0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset done=%0b tv=%0b%0b q=%h r=%h dvd=%h dvs=%h rdy=%0b required zeros rdy=1",
                  done, div_s_tvalid, div_u_tvalid, quotient, remainder,
                  div_tdata_dividend, div_tdata_divisor, req_ready);
      end
   endtask

   task automatic test_basic();
      int lat, tv; bit oth; bit held = 1;
      ip_lat = 4;
      issue(1, 100, 7);
      wait_done(1, 0, lat, tv, oth);
      checks++;
      if (lat !== 6) begin errors++; $display("FAIL basic_latency got %0d required 6", lat); end
      checks++;
      if (quotient !== 32'd14 || remainder !== 32'd2) begin
         errors++; $display("FAIL basic_result q=%0d r=%0d required 14/2", quotient, remainder);
      end
      checks++;
      if (tv !== 1) begin errors++; $display("FAIL basic_tvalid_cycles got %0d required 1", tv); end
      for (int i = 0; i < 3; i++) begin
         step();
         if (done !== 1'b1 || quotient !== 32'd14 || remainder !== 32'd2) held = 0;
      end
      checks++;
      if (!held) begin errors++; $display("FAIL basic_hold done=%0b required held 1", done); end
      ack_result();
   endtask

   task automatic test_signed_neg();
      int lat, tv; bit oth;
      ip_lat = 3;
      issue(1, 32'hFFFF_FFF9, 32'd2);
      wait_done(1, 0, lat, tv, oth);
      checks++;
      if (quotient !== 32'hFFFF_FFFD || remainder !== 32'hFFFF_FFFF) begin
         errors++; $display("FAIL neg_result q=%h r=%h required fffffffd/ffffffff", quotient, remainder);
      end
      checks++;
      if (oth || div_u_tvalid !== 1'b0) begin
         errors++; $display("FAIL neg_u_tvalid seen=%0b required 0", oth);
      end
      ack_result();
   endtask

   task automatic test_tready_stall();
      int lat, tv; bit oth;
      ip_lat = 4;
      issue(0, 32'hFFFF_FFFF, 32'h10);
      wait_done(0, 3, lat, tv, oth);
      checks++;
      if (tv !== 4) begin errors++; $display("FAIL stall_tvalid_cycles got %0d required 4", tv); end
      checks++;
      if (lat !== 2 + 3 + 4) begin errors++; $display("FAIL stall_latency got %0d required 9", lat); end
      checks++;
      if (quotient !== 32'h0FFF_FFFF || remainder !== 32'hF) begin
         errors++; $display("FAIL stall_result q=%h r=%h required 0fffffff/f", quotient, remainder);
      end
      ack_result();
   endtask

   task automatic test_flush_wait();
      int n, lat, tv; bit oth; bit done_seen = 0;
      ip_lat = 8;
      issue(1, 100, 3);
      step(); step(); step();
      n = 4;
      flush = 1'b1;
      req_valid = 1'b1; req_signed = 1'b0; req_dividend = 200; req_divisor = 10;
      if (done) done_seen = 1;
      step(); n++;
      flush = 1'b0;
      while (!req_ready && n < 60) begin
         if (done) done_seen = 1;
         step(); n++;
      end
      checks++;
      if (n !== 2 + ip_lat) begin
         errors++; $display("FAIL flushwait_ready_cycle got %0d required %0d", n, 2 + ip_lat);
      end
      step();
      req_valid = 1'b0;
      wait_done(0, 0, lat, tv, oth);
      checks++;
      if (done_seen) begin errors++; $display("FAIL flushwait_stale_done seen=1 required 0"); end
      checks++;
      if (quotient !== 32'd20 || remainder !== 32'd0 || lat !== 2 + ip_lat) begin
         errors++; $display("FAIL flushwait_new q=%0d r=%0d lat=%0d required 20/0/%0d",
                            quotient, remainder, lat, 2 + ip_lat);
      end
      ack_result();
   endtask

   task automatic test_flush_send();
      int n = 1; bit tv_ok = 1; bit done_seen = 0;
      ip_lat = 4;
      issue(0, 1000, 9);
      while (!req_ready && n < 60) begin
         divisor_tready = (n > 4);
         flush = (n == 2);
         if (div_u_tvalid !== (n <= 5)) tv_ok = 0;
         if (done) done_seen = 1;
         step(); n++;
      end
      flush = 1'b0; divisor_tready = 1'b1;
      checks++;
      if (!tv_ok) begin errors++; $display("FAIL flushsend_tvalid pattern bad required high n<=5"); end
      checks++;
      if (done_seen) begin errors++; $display("FAIL flushsend_done seen=1 required 0"); end
      checks++;
      if (n !== 5 + ip_lat + 1) begin
         errors++; $display("FAIL flushsend_idle_cycle got %0d required %0d", n, 5 + ip_lat + 1);
      end
   endtask

   task automatic test_reset_wait();
      bit done_seen = 0;
      ip_lat = 8;
      issue(1, 55, 5);
      step(); step();
      reset = 1'b1; step(); reset = 1'b0;
      checks++;
      if ({done, div_s_tvalid, div_u_tvalid, quotient, remainder, div_tdata_dividend,
           div_tdata_divisor} !== '0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL resetwait q=%h r=%h done=%0b rdy=%0b required zeros rdy=1",
                  quotient, remainder, done, req_ready);
      end
      for (int i = 0; i < 12; i++) begin if (done) done_seen = 1; step(); end
      checks++;
      if (done_seen) begin errors++; $display("FAIL resetwait_stale_done seen=1 required 0"); end
   endtask

   task automatic test_random();
      int lat, tv, stall; bit oth, s, stable;
      logic [31:0] a, b;
      logic [63:0] exp;
      for (int k = 0; k < 24; k++) begin
         s = $urandom_range(1);
         a = $urandom;
         b = (k == 0) ? 32'd0 : (($urandom_range(1) == 1) ? $urandom : $urandom_range(255));
         if (k != 0 && b == 0) b = 1;
         if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 1;
         stall = $urandom_range(3);
         ip_lat = $urandom_range(5, 1);
         exp = ref_div(s, a, b);
         issue(s, a, b);
         wait_done(s, stall, lat, tv, oth);
         checks++;
         if (quotient !== exp[63:32] || remainder !== exp[31:0] || lat !== 2 + stall + ip_lat) begin
            errors++;
            $display("FAIL rand_%0d s=%0b %h/%h q=%h r=%h lat=%0d required %h/%h lat=%0d",
                     k, s, a, b, quotient, remainder, lat, exp[63:32], exp[31:0], 2 + stall + ip_lat);
         end
         stable = 1;
         for (int d = $urandom_range(2); d > 0; d--) begin
            step();
            if (done !== 1'b1 || {quotient, remainder} !== exp) stable = 0;
         end
         checks++;
         if (!stable) begin errors++; $display("FAIL rand_hold_%0d done=%0b required held", k, done); end
         ack_result();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_signed_neg();
      test_tready_stall();
      test_flush_wait();
      test_flush_send();
      test_reset_wait();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
